// File: rtl/vga_timing_detector_if.sv
// Signal bundle between a VGA timing source (master) and the timing detector (slave).
interface vga_timing_detector_if #(
    parameter int HW = 11,
    parameter int VW = 10
);
    logic          hsync_in;
    logic          vsync_in;
    logic          de_in;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          pix_valid;
    logic [HW-1:0] h_total;
    logic [HW-1:0] h_sync_len;
    logic [HW-1:0] h_active;
    logic [VW-1:0] v_total;
    logic [VW-1:0] v_sync_len;
    logic [VW-1:0] v_active;
    logic          locked;
    logic          frame_start;
    logic          err;

    modport master (
        output hsync_in, vsync_in, de_in,
        input  x, y, pix_valid,
        input  h_total, h_sync_len, h_active,
        input  v_total, v_sync_len, v_active,
        input  locked, frame_start, err
    );

    modport slave (
        input  hsync_in, vsync_in, de_in,
        output x, y, pix_valid,
        output h_total, h_sync_len, h_active,
        output v_total, v_sync_len, v_active,
        output locked, frame_start, err
    );
endinterface

// File: rtl/vga_timing_detector.sv
// Measures VGA line/frame geometry from hsync/vsync/de, recovers pixel x/y and reports timing lock.
module vga_timing_detector #(
    parameter int HW          = 11,
    parameter int VW          = 10,
    parameter int SYNC_POL    = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int TOL         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_timing_detector_if.slave  bus
);

    localparam int         MW      = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic       POL_INV = (SYNC_POL == 0);
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic hs_p1, vs_p1, de_p1;
    logic hs_p2, vs_p2, de_p2;
    logic hs_rise, hs_fall, vs_rise, de_rise, de_fall;

    logic [HW-1:0] pcnt, line_len, hs_cnt, hs_len, de_cnt, de_len, x_cnt;
    logic [VW-1:0] line_cnt, vs_lines, act_lines, y_cnt;

    logic [HW-1:0] snap_htot, snap_hsync, snap_hact;
    logic [VW-1:0] snap_vtot, snap_vsync, snap_vact;
    logic [HW-1:0] out_htot, out_hsync, out_hact;
    logic [VW-1:0] out_vtot, out_vsync, out_vact;

    logic [1:0]    state;
    logic [MW-1:0] match, next_match;
    logic          locked, frame_start, err;
    logic          timeout, fields_near;

    function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
        sat_inc_h = (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
        sat_inc_v = (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic near(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d    = (a >= b) ? (a - b) : (b - a);
        near = (d <= $unsigned(TOL));
    endfunction

    // Stage 1: polarity-normalised samples; stage 2: delayed copies for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p1 <= 1'b0;
            vs_p1 <= 1'b0;
            de_p1 <= 1'b0;
            hs_p2 <= 1'b0;
            vs_p2 <= 1'b0;
            de_p2 <= 1'b0;
        end else begin
            hs_p1 <= bus.hsync_in ^ POL_INV;
            vs_p1 <= bus.vsync_in ^ POL_INV;
            de_p1 <= bus.de_in;
            hs_p2 <= hs_p1;
            vs_p2 <= vs_p1;
            de_p2 <= de_p1;
        end
    end

    assign hs_rise = hs_p1 & ~hs_p2;
    assign hs_fall = ~hs_p1 & hs_p2;
    assign vs_rise = vs_p1 & ~vs_p2;
    assign de_rise = de_p1 & ~de_p2;
    assign de_fall = ~de_p1 & de_p2;

    // Horizontal measurements; h fields hold the last complete line
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt     <= '0;
            line_len <= '0;
            hs_cnt   <= '0;
            hs_len   <= '0;
            de_cnt   <= '0;
            de_len   <= '0;
        end else begin
            if (hs_rise) begin
                line_len <= pcnt;
                pcnt     <= HW'(1);
            end else begin
                pcnt <= sat_inc_h(pcnt);
            end

            if (hs_fall) begin
                hs_len <= hs_cnt;
                hs_cnt <= '0;
            end else if (hs_p1) begin
                hs_cnt <= sat_inc_h(hs_cnt);
            end

            if (de_fall) begin
                de_len <= de_cnt;
                de_cnt <= '0;
            end else if (de_p1) begin
                de_cnt <= sat_inc_h(de_cnt);
            end
        end
    end

    // Vertical measurements; an event coinciding with vs rise belongs to the new frame
    always_ff @(posedge clk) begin
        if (reset) begin
            line_cnt  <= '0;
            vs_lines  <= '0;
            act_lines <= '0;
        end else if (vs_rise) begin
            line_cnt  <= VW'(hs_rise);
            vs_lines  <= VW'(hs_rise);
            act_lines <= VW'(de_fall);
        end else begin
            if (hs_rise)
                line_cnt <= sat_inc_v(line_cnt);
            if (hs_rise && vs_p1)
                vs_lines <= sat_inc_v(vs_lines);
            if (de_fall)
                act_lines <= sat_inc_v(act_lines);
        end
    end

    // Pixel coordinates, aligned with de_p2 (pix_valid)
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (de_rise) begin
            x_cnt <= '0;
            y_cnt <= vs_rise ? '0 : act_lines;
        end else if (de_p1) begin
            x_cnt <= sat_inc_h(x_cnt);
        end
    end

    // Snapshot on vs rise; published fields follow one clock after frame_start
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start <= 1'b0;
            snap_htot   <= '0;
            snap_hsync  <= '0;
            snap_hact   <= '0;
            snap_vtot   <= '0;
            snap_vsync  <= '0;
            snap_vact   <= '0;
            out_htot    <= '0;
            out_hsync   <= '0;
            out_hact    <= '0;
            out_vtot    <= '0;
            out_vsync   <= '0;
            out_vact    <= '0;
        end else begin
            frame_start <= vs_rise;
            if (vs_rise) begin
                snap_htot  <= line_len;
                snap_hsync <= hs_len;
                snap_hact  <= de_len;
                snap_vtot  <= line_cnt;
                snap_vsync <= vs_lines;
                snap_vact  <= act_lines;
            end
            if (frame_start) begin
                out_htot  <= snap_htot;
                out_hsync <= snap_hsync;
                out_hact  <= snap_hact;
                out_vtot  <= snap_vtot;
                out_vsync <= snap_vsync;
                out_vact  <= snap_vact;
            end
        end
    end

    assign timeout = (pcnt == '1);

    assign fields_near = near(32'(line_len),  32'(snap_htot))  &
                         near(32'(hs_len),    32'(snap_hsync)) &
                         near(32'(de_len),    32'(snap_hact))  &
                         near(32'(line_cnt),  32'(snap_vtot))  &
                         near(32'(vs_lines),  32'(snap_vsync)) &
                         near(32'(act_lines), 32'(snap_vact));

    // match==0 means the stored snapshot is not yet a trusted reference (partial frame
    // after search, or the frame that broke lock), so the current frame starts a new run.
    always_comb begin
        next_match = '0;
        if (match == '0)
            next_match = MW'(1);
        else if (fields_near)
            next_match = match + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_SEARCH;
            match  <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (timeout) begin
                state  <= ST_SEARCH;
                match  <= '0;
                locked <= 1'b0;
                if (state == ST_LOCKED)
                    err <= 1'b1;
            end else if (vs_rise) begin
                case (state)
                    ST_SEARCH: begin
                        state <= ST_CHECK;
                        match <= '0;
                    end
                    ST_CHECK: begin
                        match <= next_match;
                        if (next_match == MW'(LOCK_FRAMES)) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!fields_near) begin
                            err    <= 1'b1;
                            locked <= 1'b0;
                            state  <= ST_CHECK;
                            match  <= '0;
                        end
                    end
                    default: begin
                        state <= ST_SEARCH;
                        match <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.x           = x_cnt;
    assign bus.y           = y_cnt;
    assign bus.pix_valid   = de_p2;
    assign bus.h_total     = out_htot;
    assign bus.h_sync_len  = out_hsync;
    assign bus.h_active    = out_hact;
    assign bus.v_total     = out_vtot;
    assign bus.v_sync_len  = out_vsync;
    assign bus.v_active    = out_vact;
    assign bus.locked      = locked;
    assign bus.frame_start = frame_start;
    assign bus.err         = err;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector on a reduced raster (40 clk x 12 lines), both sync polarities.
module tb_vga_timing_detector;
    localparam int HW = 11;
    localparam int VW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic hs    = 1'b0;
    logic vs    = 1'b0;
    logic de    = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_detector_if #(.HW(HW), .VW(VW)) bus_a ();
    vga_timing_detector_if #(.HW(HW), .VW(VW)) bus_b ();

    assign bus_a.hsync_in = hs;
    assign bus_a.vsync_in = vs;
    assign bus_a.de_in    = de;
    assign bus_b.hsync_in = ~hs;
    assign bus_b.vsync_in = ~vs;
    assign bus_b.de_in    = de;

    vga_timing_detector #(.HW(HW), .VW(VW), .SYNC_POL(1), .LOCK_FRAMES(2), .TOL(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    vga_timing_detector #(.HW(HW), .VW(VW), .SYNC_POL(0), .LOCK_FRAMES(2), .TOL(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    // Event monitors: frame_start/err pulse counts and the frame_start count at which lock rose
    int   fs_a, err_a, lock_at_a, err_at_a;
    int   fs_b, lock_at_b;
    logic lk_prev_a, lk_prev_b;

    always @(negedge clk) begin
        if (reset) begin
            fs_a <= 0; err_a <= 0; lock_at_a <= 0; err_at_a <= 0; lk_prev_a <= 1'b0;
            fs_b <= 0; lock_at_b <= 0; lk_prev_b <= 1'b0;
        end else begin
            fs_a <= fs_a + (bus_a.frame_start ? 1 : 0);
            fs_b <= fs_b + (bus_b.frame_start ? 1 : 0);
            if (bus_a.err) begin
                err_a    <= err_a + 1;
                err_at_a <= fs_a + (bus_a.frame_start ? 1 : 0);
            end
            if (bus_a.locked && !lk_prev_a)
                lock_at_a <= fs_a + (bus_a.frame_start ? 1 : 0);
            if (bus_b.locked && !lk_prev_b)
                lock_at_b <= fs_b + (bus_b.frame_start ? 1 : 0);
            lk_prev_a <= bus_a.locked;
            lk_prev_b <= bus_b.locked;
        end
    end

    task automatic drive_pix(input int l, input int p);
        @(posedge clk);
        #1;
        hs = (p >= 30 && p <= 35);
        vs = (l >= 9 && l <= 10);
        de = (p <= 24 && l < 8);
    endtask

    task automatic gen_line(input int l, input int htot);
        for (int p = 0; p < htot; p++) drive_pix(l, p);
    endtask

    task automatic gen_frames(input int n, input int htot, input int first_line);
        for (int f = 0; f < n; f++)
            for (int l = (f == 0) ? first_line : 0; l < 12; l++) gen_line(l, htot);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_a.h_total, bus_a.h_sync_len, bus_a.h_active} !== 33'd0) begin
            n_bad++; $display("FAIL reset_h got %h want 0", {bus_a.h_total, bus_a.h_sync_len, bus_a.h_active});
        end
        n_cmp++;
        if ({bus_a.v_total, bus_a.v_sync_len, bus_a.v_active} !== 30'd0) begin
            n_bad++; $display("FAIL reset_v got %h want 0", {bus_a.v_total, bus_a.v_sync_len, bus_a.v_active});
        end
        n_cmp++;
        if ({bus_a.x, bus_a.y, bus_a.pix_valid, bus_a.locked, bus_a.frame_start, bus_a.err} !== 25'd0) begin
            n_bad++; $display("FAIL reset_flags got %h want 0",
                              {bus_a.x, bus_a.y, bus_a.pix_valid, bus_a.locked, bus_a.frame_start, bus_a.err});
        end
        n_cmp++;
        if ({bus_b.h_total, bus_b.v_total, bus_b.locked, bus_b.err} !== 23'd0) begin
            n_bad++; $display("FAIL reset_b got %h want 0", {bus_b.h_total, bus_b.v_total, bus_b.locked, bus_b.err});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lock;
        gen_frames(3, 40, 0);
        n_cmp++;
        if (bus_a.h_total !== 11'd40) begin n_bad++; $display("FAIL h_total got %0d want 40", bus_a.h_total); end
        n_cmp++;
        if (bus_a.h_sync_len !== 11'd6) begin n_bad++; $display("FAIL h_sync_len got %0d want 6", bus_a.h_sync_len); end
        n_cmp++;
        if (bus_a.h_active !== 11'd25) begin n_bad++; $display("FAIL h_active got %0d want 25", bus_a.h_active); end
        n_cmp++;
        if (bus_a.v_total !== 10'd12) begin n_bad++; $display("FAIL v_total got %0d want 12", bus_a.v_total); end
        n_cmp++;
        if (bus_a.v_sync_len !== 10'd2) begin n_bad++; $display("FAIL v_sync_len got %0d want 2", bus_a.v_sync_len); end
        n_cmp++;
        if (bus_a.v_active !== 10'd8) begin n_bad++; $display("FAIL v_active got %0d want 8", bus_a.v_active); end
        n_cmp++;
        if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL locked got %b want 1", bus_a.locked); end
        n_cmp++;
        if (lock_at_a != 3) begin n_bad++; $display("FAIL lock_vs_rise got %0d want 3", lock_at_a); end
        n_cmp++;
        if (fs_a != 3) begin n_bad++; $display("FAIL frame_start_count got %0d want 3", fs_a); end
        n_cmp++;
        if (err_a != 0) begin n_bad++; $display("FAIL err_count got %0d want 0", err_a); end
    endtask

    task automatic test_sync_pol;
        n_cmp++;
        if ({bus_b.h_total, bus_b.h_sync_len, bus_b.h_active} !== {11'd40, 11'd6, 11'd25}) begin
            n_bad++; $display("FAIL pol0_h got %0d/%0d/%0d want 40/6/25", bus_b.h_total, bus_b.h_sync_len, bus_b.h_active);
        end
        n_cmp++;
        if ({bus_b.v_total, bus_b.v_sync_len, bus_b.v_active} !== {10'd12, 10'd2, 10'd8}) begin
            n_bad++; $display("FAIL pol0_v got %0d/%0d/%0d want 12/2/8", bus_b.v_total, bus_b.v_sync_len, bus_b.v_active);
        end
        n_cmp++;
        if (bus_b.locked !== 1'b1) begin n_bad++; $display("FAIL pol0_locked got %b want 1", bus_b.locked); end
        n_cmp++;
        if (lock_at_b != 3) begin n_bad++; $display("FAIL pol0_lock_vs_rise got %0d want 3", lock_at_b); end
    endtask

    task automatic test_pixel_coords;
        logic [HW-1:0] exp_x;
        logic [VW-1:0] exp_y;
        logic          exp_pv;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 40; p++) begin
                drive_pix(l, p);
                @(negedge clk);
                exp_pv = (p >= 2 && p <= 26);
                n_cmp++;
                if (bus_a.pix_valid !== exp_pv) begin
                    n_bad++; $display("FAIL pix_valid l%0d p%0d got %b want %b", l, p, bus_a.pix_valid, exp_pv);
                end
                if (exp_pv) begin
                    exp_x = HW'(p - 2);
                    exp_y = VW'(l);
                    n_cmp++;
                    if (bus_a.x !== exp_x) begin
                        n_bad++; $display("FAIL x l%0d p%0d got %0d want %0d", l, p, bus_a.x, exp_x);
                    end
                    n_cmp++;
                    if (bus_a.y !== exp_y) begin
                        n_bad++; $display("FAIL y l%0d p%0d got %0d want %0d", l, p, bus_a.y, exp_y);
                    end
                end
            end
        end
        for (int l = 2; l < 12; l++) gen_line(l, 40);
        n_cmp++;
        if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL pixel_locked got %b want 1", bus_a.locked); end
    endtask

    task automatic test_mismatch;
        int fs0, e0;
        fs0 = fs_a;
        e0  = err_a;
        gen_frames(1, 41, 0);
        n_cmp++;
        if (err_a != e0 + 1) begin n_bad++; $display("FAIL mm_err_count got %0d want %0d", err_a, e0 + 1); end
        n_cmp++;
        if (err_at_a != fs0 + 1) begin n_bad++; $display("FAIL mm_err_at got %0d want %0d", err_at_a, fs0 + 1); end
        n_cmp++;
        if (bus_a.locked !== 1'b0) begin n_bad++; $display("FAIL mm_unlocked got %b want 0", bus_a.locked); end
        n_cmp++;
        if (bus_a.h_total !== 11'd41) begin n_bad++; $display("FAIL mm_h_total got %0d want 41", bus_a.h_total); end
        gen_frames(2, 40, 0);
        n_cmp++;
        if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL mm_relocked got %b want 1", bus_a.locked); end
        n_cmp++;
        if (lock_at_a != fs0 + 3) begin n_bad++; $display("FAIL mm_relock_at got %0d want %0d", lock_at_a, fs0 + 3); end
        n_cmp++;
        if (err_a != e0 + 1) begin n_bad++; $display("FAIL mm_err_after got %0d want %0d", err_a, e0 + 1); end
        n_cmp++;
        if (bus_a.h_total !== 11'd40) begin n_bad++; $display("FAIL mm_h_total_back got %0d want 40", bus_a.h_total); end
    endtask

    task automatic test_timeout;
        int fs0, e0;
        e0 = err_a;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk);
            #1;
            hs = 1'b0; vs = 1'b0; de = 1'b0;
        end
        n_cmp++;
        if (err_a != e0 + 1) begin n_bad++; $display("FAIL to_err_count got %0d want %0d", err_a, e0 + 1); end
        n_cmp++;
        if (bus_a.locked !== 1'b0) begin n_bad++; $display("FAIL to_unlocked got %b want 0", bus_a.locked); end
        n_cmp++;
        if ({bus_a.h_total, bus_a.h_sync_len, bus_a.h_active} !== {11'd40, 11'd6, 11'd25}) begin
            n_bad++; $display("FAIL to_keep_h got %0d/%0d/%0d want 40/6/25", bus_a.h_total, bus_a.h_sync_len, bus_a.h_active);
        end
        n_cmp++;
        if ({bus_a.v_total, bus_a.v_sync_len, bus_a.v_active} !== {10'd12, 10'd2, 10'd8}) begin
            n_bad++; $display("FAIL to_keep_v got %0d/%0d/%0d want 12/2/8", bus_a.v_total, bus_a.v_sync_len, bus_a.v_active);
        end
        fs0 = fs_a;
        gen_frames(3, 40, 0);
        n_cmp++;
        if (lock_at_a != fs0 + 3) begin n_bad++; $display("FAIL to_relock_at got %0d want %0d", lock_at_a, fs0 + 3); end
        n_cmp++;
        if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL to_relocked got %b want 1", bus_a.locked); end
        n_cmp++;
        if (err_a != e0 + 1) begin n_bad++; $display("FAIL to_err_after got %0d want %0d", err_a, e0 + 1); end
    endtask

    task automatic test_reset_mid;
        for (int l = 0; l < 5; l++) gen_line(l, 40);
        @(posedge clk);
        #1;
        reset = 1'b1;
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus_a.h_total, bus_a.h_sync_len, bus_a.h_active, bus_a.v_total, bus_a.v_sync_len, bus_a.v_active} !== 63'd0) begin
            n_bad++; $display("FAIL rm_fields got %0d/%0d want 0/0", bus_a.h_total, bus_a.v_total);
        end
        n_cmp++;
        if ({bus_a.x, bus_a.y, bus_a.pix_valid, bus_a.locked, bus_a.frame_start, bus_a.err} !== 25'd0) begin
            n_bad++; $display("FAIL rm_flags got %h want 0",
                              {bus_a.x, bus_a.y, bus_a.pix_valid, bus_a.locked, bus_a.frame_start, bus_a.err});
        end
        gen_frames(3, 40, 5);
        n_cmp++;
        if (lock_at_a != 3) begin n_bad++; $display("FAIL rm_lock_at got %0d want 3", lock_at_a); end
        n_cmp++;
        if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL rm_locked got %b want 1", bus_a.locked); end
        n_cmp++;
        if (lock_at_b != 3) begin n_bad++; $display("FAIL rm_pol0_lock_at got %0d want 3", lock_at_b); end
        n_cmp++;
        if ({bus_a.h_total, bus_a.v_total, bus_a.v_active} !== {11'd40, 10'd12, 10'd8}) begin
            n_bad++; $display("FAIL rm_fields_back got %0d/%0d/%0d want 40/12/8", bus_a.h_total, bus_a.v_total, bus_a.v_active);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_sync_pol();
        test_pixel_coords();
        test_mismatch();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
